// File: rtl/sdram_init_monitor.sv
// sdram_init_monitor: passive device-side checker for the SDRAM power-up sequence.
// Decodes cmd/addr like a device, captures the mode word, latches the first violation.
module sdram_init_monitor #(
    parameter int T_POWERUP    = 20000,
    parameter int T_RP         = 2,
    parameter int T_RFC        = 7,
    parameter int T_MRD        = 3,
    parameter int REF_MIN      = 2,
    parameter int DONE_TIMEOUT = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_ba,
    input  logic [11:0] init_addr,
    input  logic        init_done,
    output logic        mon_ready,
    output logic        mon_err,
    output logic [2:0]  mon_err_code,
    output logic [3:0]  ref_count,
    output logic [2:0]  mr_bl,
    output logic        mr_bt,
    output logic [2:0]  mr_cl,
    output logic        mr_wb
);
    localparam int CW = $clog2(T_POWERUP + 1);
    localparam int DW = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CW-1:0] PWR_C = CW'(T_POWERUP);
    localparam logic [CW-1:0] RP_C  = CW'(T_RP);
    localparam logic [CW-1:0] RFC_C = CW'(T_RFC);
    localparam logic [CW-1:0] MRD_C = CW'(T_MRD);
    localparam logic [DW-1:0] DTO_C = DW'(DONE_TIMEOUT - 1);
    localparam logic [3:0]    RMIN_C = 4'(REF_MIN);

    typedef enum logic [2:0] {
        PWR_WAIT, TRP, TRFC, TMRD, DONE, ERR
    } state_t;

    localparam logic [2:0] E_NONE   = 3'd0;
    localparam logic [2:0] E_TIMING = 3'd1;
    localparam logic [2:0] E_SEQ    = 3'd2;
    localparam logic [2:0] E_MODE   = 3'd3;
    localparam logic [2:0] E_EARLY  = 3'd4;
    localparam logic [2:0] E_NODONE = 3'd5;

    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [DW-1:0] done_cnt;
    logic done_seen;
    logic [2:0] err_nx;
    logic accept, ref_inc, capture;
    logic is_nop, is_pre, is_ref, is_lmr;
    logic mode_bad;
    logic addr_unused;

    // Bank and the address bits outside the mode word are observed only.
    assign addr_unused = ^{init_ba, init_addr[11], init_addr[8:7]};

    assign is_nop = init_cmd[3] || (init_cmd == 4'b0111);
    assign is_pre = (init_cmd == 4'b0010);
    assign is_ref = (init_cmd == 4'b0001);
    assign is_lmr = (init_cmd == 4'b0000);

    // Legal: CAS latency 2/3; burst 1/2/4/8, or full page only when sequential.
    assign mode_bad = !(init_addr[6:4] == 3'd2 || init_addr[6:4] == 3'd3)
                   || !(init_addr[2:0] <= 3'd3
                        || (init_addr[2:0] == 3'd7 && !init_addr[3]));

    always_comb begin
        state_nx = state;
        err_nx   = E_NONE;
        accept   = 1'b0;
        ref_inc  = 1'b0;
        capture  = 1'b0;
        unique case (state)
            PWR_WAIT: if (!is_nop) begin
                if (cnt < PWR_C) err_nx = E_TIMING;
                else if (is_pre && init_addr[10]) begin
                    state_nx = TRP;
                    accept   = 1'b1;
                end else err_nx = E_SEQ;
            end
            TRP: if (!is_nop) begin
                if (cnt < RP_C) err_nx = E_TIMING;
                else if (is_ref) begin
                    state_nx = TRFC;
                    accept   = 1'b1;
                    ref_inc  = 1'b1;
                end else err_nx = E_SEQ;
            end
            TRFC: if (!is_nop) begin
                if (cnt < RFC_C) err_nx = E_TIMING;
                else if (is_ref) begin
                    accept  = 1'b1;
                    ref_inc = 1'b1;
                end else if (is_lmr && ref_count >= RMIN_C) begin
                    state_nx = TMRD;
                    accept   = 1'b1;
                    capture  = 1'b1;
                    if (mode_bad) err_nx = E_MODE;
                end else err_nx = E_SEQ;
            end
            TMRD: begin
                if (!is_nop) err_nx = E_TIMING;
                else if (cnt >= MRD_C) state_nx = DONE;
            end
            DONE: begin
                if (!done_seen && !init_done && done_cnt >= DTO_C)
                    err_nx = E_NODONE;
            end
            default: ;
        endcase
        if (init_done && (state == PWR_WAIT || state == TRP || state == TRFC))
            err_nx = E_EARLY;
        if (err_nx != E_NONE) begin
            state_nx = ERR;
            ref_inc  = 1'b0;
            accept   = 1'b0;
        end
        if (err_nx != E_NONE && err_nx != E_MODE) capture = 1'b0;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= PWR_WAIT;
            cnt          <= '0;
            done_cnt     <= '0;
            done_seen    <= 1'b0;
            mon_ready    <= 1'b0;
            mon_err      <= 1'b0;
            mon_err_code <= E_NONE;
            ref_count    <= '0;
            mr_bl        <= '0;
            mr_bt        <= 1'b0;
            mr_cl        <= '0;
            mr_wb        <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) cnt <= CW'(1);
            else if (cnt != '1) cnt <= cnt + 1'b1;
            if (state == DONE) begin
                if (done_cnt != '1) done_cnt <= done_cnt + 1'b1;
                if (init_done) done_seen <= 1'b1;
            end
            if (ref_inc && ref_count != 4'hf) ref_count <= ref_count + 1'b1;
            if (capture) begin
                mr_bl <= init_addr[2:0];
                mr_bt <= init_addr[3];
                mr_cl <= init_addr[6:4];
                mr_wb <= init_addr[9];
            end
            if (err_nx != E_NONE) begin
                mon_err      <= 1'b1;
                mon_err_code <= err_nx;
            end
            mon_ready <= (state == DONE) && (err_nx == E_NONE);
        end
    end
endmodule

// File: tb/tb_sdram_init_monitor.sv
// tb_sdram_init_monitor: directed power-up sequences, checked each cycle against
// a model that reasons in elapsed cycles since reset and since the last command.
`timescale 1ns/1ps
module tb_sdram_init_monitor;
    localparam int TPU  = 10;
    localparam int TRPV = 2;
    localparam int TRFV = 7;
    localparam int TMRV = 3;
    localparam int RMIN = 2;
    localparam int DTO  = 16;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] LMR = 4'b0000;
    localparam logic [3:0] ACT = 4'b0011;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [3:0]  init_cmd = NOP;
    logic [1:0]  init_ba = 2'd0;
    logic [11:0] init_addr = 12'd0;
    logic        init_done = 1'b0;
    logic        mon_ready, mon_err, mr_bt, mr_wb;
    logic [2:0]  mon_err_code, mr_bl, mr_cl;
    logic [3:0]  ref_count;

    sdram_init_monitor #(
        .T_POWERUP(TPU), .T_RP(TRPV), .T_RFC(TRFV), .T_MRD(TMRV),
        .REF_MIN(RMIN), .DONE_TIMEOUT(DTO)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_cmd(init_cmd),
        .init_ba(init_ba), .init_addr(init_addr), .init_done(init_done),
        .mon_ready(mon_ready), .mon_err(mon_err), .mon_err_code(mon_err_code),
        .ref_count(ref_count), .mr_bl(mr_bl), .mr_bt(mr_bt),
        .mr_cl(mr_cl), .mr_wb(mr_wb)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Model: time of power-up release is cycle 0; track command times.
    int cyc, pre_t, last_t, refs, lmr_t;
    bit seen;
    int e_ready, e_err, e_code, e_ref, e_bl, e_bt, e_cl, e_wb;

    task automatic model_reset();
        cyc = 0; pre_t = -1; last_t = 0; refs = 0; lmr_t = -1; seen = 0;
        e_ready = 0; e_err = 0; e_code = 0; e_ref = 0;
        e_bl = 0; e_bt = 0; e_cl = 0; e_wb = 0;
    endtask

    function automatic bit mode_ok(input logic [11:0] a);
        int cl, bl;
        cl = int'(a[6:4]);
        bl = int'(a[2:0]);
        if (cl != 2 && cl != 3) return 0;
        if (bl <= 3) return 1;
        return (bl == 7 && a[3] == 1'b0);
    endfunction

    task automatic model_step();
        int code, el, need, d;
        bit nop, in_done;
        code = 0;
        nop = init_cmd[3] || init_cmd == NOP;
        in_done = lmr_t >= 0 && cyc >= lmr_t + TMRV + 1;
        if (e_err == 0) begin
            el = (pre_t < 0) ? cyc : cyc - last_t;
            if (init_done && lmr_t < 0) code = 4;
            else if (lmr_t < 0) begin
                if (!nop) begin
                    need = (pre_t < 0) ? TPU : ((refs == 0) ? TRPV : TRFV);
                    if (el < need) code = 1;
                    else if (pre_t < 0) begin
                        if (init_cmd == PRE && init_addr[10]) begin
                            pre_t = cyc; last_t = cyc;
                        end else code = 2;
                    end else if (init_cmd == REF) begin
                        refs++; last_t = cyc;
                    end else if (init_cmd == LMR && refs >= RMIN) begin
                        lmr_t = cyc; last_t = cyc;
                        e_bl = int'(init_addr[2:0]);
                        e_bt = int'(init_addr[3]);
                        e_cl = int'(init_addr[6:4]);
                        e_wb = int'(init_addr[9]);
                        if (!mode_ok(init_addr)) code = 3;
                    end else code = 2;
                end
            end else if (!in_done) begin
                if (!nop) code = 1;
            end else begin
                d = cyc - (lmr_t + TMRV + 1);
                if (init_done) seen = 1;
                else if (!seen && d == DTO - 1) code = 5;
            end
            if (code != 0) begin
                e_err = 1; e_code = code;
            end
            e_ready = (in_done && code == 0) ? 1 : 0;
            e_ref = refs;
        end
        cyc++;
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst) model_reset();
        chk("ready", mon_ready, e_ready);
        chk("err", mon_err, e_err);
        chk("code", mon_err_code, e_code);
        chk("ref_count", ref_count, e_ref);
        chk("mr_bl", mr_bl, e_bl);
        chk("mr_bt", mr_bt, e_bt);
        chk("mr_cl", mr_cl, e_cl);
        chk("mr_wb", mr_wb, e_wb);
        if (!sys_rst) model_step();
    end

    task automatic drive(input logic [3:0] c, input logic [11:0] a,
                         input logic d, input int n);
        repeat (n) begin
            init_cmd = c; init_addr = a; init_done = d;
            @(posedge sys_clk); #1;
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        init_cmd = NOP; init_addr = 12'd0; init_done = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
    endtask

    task automatic to_trfc();
        drive(NOP, 12'h000, 1'b0, TPU);
        drive(PRE, 12'h400, 1'b0, 1);
        drive(NOP, 12'h000, 1'b0, 1);
        drive(REF, 12'h000, 1'b0, 1);
    endtask

    task automatic legal_to_lmr(input logic [11:0] mode);
        to_trfc();
        drive(NOP, 12'h000, 1'b0, 6);
        drive(REF, 12'h000, 1'b0, 1);
        drive(NOP, 12'h000, 1'b0, 6);
        drive(LMR, mode, 1'b0, 1);
        drive(NOP, 12'h000, 1'b0, 3);
    endtask

    initial begin
        model_reset();
        do_reset();
        chk("rst_ready", mon_ready, 0);
        chk("rst_code", mon_err_code, 0);

        legal_to_lmr(12'h032);
        drive(NOP, 12'h000, 1'b1, 4);
        chk("t1_ready", mon_ready, 1);
        chk("t1_refs", ref_count, 2);
        chk("t1_cl", mr_cl, 3);
        chk("t1_bl", mr_bl, 2);
        chk("t1_code", mon_err_code, 0);

        do_reset();
        drive(NOP, 12'h000, 1'b0, TPU - 1);
        drive(PRE, 12'h400, 1'b0, 1);
        drive(NOP, 12'h000, 1'b0, 2);
        chk("t2_err", mon_err, 1);
        chk("t2_code", mon_err_code, 1);
        chk("t2_ready", mon_ready, 0);

        do_reset();
        to_trfc();
        drive(NOP, 12'h000, 1'b0, 6);
        drive(LMR, 12'h032, 1'b0, 1);
        drive(NOP, 12'h000, 1'b0, 2);
        chk("t3a_code", mon_err_code, 2);
        chk("t3a_refs", ref_count, 1);

        do_reset();
        drive(NOP, 12'h000, 1'b0, TPU);
        drive(PRE, 12'h000, 1'b0, 1);
        drive(NOP, 12'h000, 1'b0, 2);
        chk("t3b_code", mon_err_code, 2);

        do_reset();
        drive(NOP, 12'h000, 1'b0, TPU);
        drive(PRE, 12'h400, 1'b0, 1);
        drive(NOP, 12'h000, 1'b0, 1);
        drive(ACT, 12'h000, 1'b0, 1);
        drive(NOP, 12'h000, 1'b0, 2);
        chk("t3c_code", mon_err_code, 2);

        do_reset();
        legal_to_lmr(12'h012);
        drive(NOP, 12'h000, 1'b1, 2);
        chk("t4_code", mon_err_code, 3);
        chk("t4_cl", mr_cl, 1);
        chk("t4_ready", mon_ready, 0);

        do_reset();
        legal_to_lmr(12'h03F);
        drive(NOP, 12'h000, 1'b1, 2);
        chk("t4b_code", mon_err_code, 3);
        chk("t4b_bl", mr_bl, 7);
        chk("t4b_bt", mr_bt, 1);

        do_reset();
        legal_to_lmr(12'h227);
        drive(NOP, 12'h000, 1'b1, 3);
        chk("fp_ready", mon_ready, 1);
        chk("fp_bl", mr_bl, 7);
        chk("fp_cl", mr_cl, 2);
        chk("fp_wb", mr_wb, 1);

        do_reset();
        to_trfc();
        drive(NOP, 12'h000, 1'b0, 2);
        drive(NOP, 12'h000, 1'b1, 1);
        drive(NOP, 12'h000, 1'b0, 2);
        chk("t5a_code", mon_err_code, 4);

        do_reset();
        legal_to_lmr(12'h032);
        drive(NOP, 12'h000, 1'b0, 2);
        chk("t5b_ready", mon_ready, 1);
        drive(NOP, 12'h000, 1'b0, DTO - 2);
        chk("t5b_code", mon_err_code, 5);
        chk("t5b_ready0", mon_ready, 0);

        do_reset();
        to_trfc();
        drive(NOP, 12'h000, 1'b0, 2);
        drive(REF, 12'h000, 1'b0, 1);
        drive(NOP, 12'h000, 1'b0, 2);
        chk("t6_code", mon_err_code, 1);
        sys_rst = 1'b1;
        #1;
        chk("t6_rst_err", mon_err, 0);
        chk("t6_rst_code", mon_err_code, 0);
        chk("t6_rst_refs", ref_count, 0);
        do_reset();
        legal_to_lmr(12'h032);
        drive(NOP, 12'h000, 1'b1, 4);
        chk("t6_ready", mon_ready, 1);
        chk("t6_code2", mon_err_code, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
